// File: rtl/pe_row_drain.sv
// pe_row_drain
// Drains one systolic PE row after a multiply pass. The controller enables
// the row for the pass, snapshots every partial sum into a shadow register
// once the last skewed beat has settled, then streams the elements out one
// per valid/ready handshake. Element 0 is streamed first.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      pass start pulse; first operand beat is in this cycle
//   row_result Y_COL*RW concatenated PE results, element 0 in the MSB slice
//   pe_en      enable to the PE row during a pass
//   busy       controller is not idle
//   m_valid    output element valid
//   m_ready    downstream accepts the element
//   m_data     current element
//   m_index    index of the current element
//   m_last     current element is the final one
//   overrun    sticky flag: start seen while busy
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | PE row enabled, counting beats plus skew
// DRAIN  | shadow captured, streaming elements
module pe_row_drain #(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
  parameter int Y_COL                    = 2,
  parameter int K_DEPTH                  = 3,
  localparam int RW = BITWIDTH * (IS_BITWIDTH_DOUBLE_SCALE + 1),
  localparam int IW = (Y_COL > 1) ? $clog2(Y_COL) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [Y_COL*RW-1:0]   row_result,
  output logic                  pe_en,
  output logic                  busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RW-1:0]         m_data,
  output logic [IW-1:0]         m_index,
  output logic                  m_last,
  output logic                  overrun
);

  localparam int CW = $clog2(K_DEPTH + Y_COL);
  localparam logic [CW-1:0] CNT_LOAD = CW'(K_DEPTH + Y_COL - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(Y_COL - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]          state_q,   state_d;
  logic [CW-1:0]       cnt_q,     cnt_d;
  logic [IW-1:0]       idx_q,     idx_d;
  logic [Y_COL*RW-1:0] shadow_q,  shadow_d;
  logic                overrun_q, overrun_d;

  logic          is_last;
  logic          xfer;
  logic [RW-1:0] slice;

  assign is_last = (idx_q == IDX_LAST);
  assign xfer    = (state_q == ST_DRAIN) && m_ready;

  always_comb begin
    slice = '0;
    for (int i = 0; i < Y_COL; i++) begin
      if (idx_q == IW'(i)) slice = shadow_q[(Y_COL-1-i)*RW +: RW];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_RUN: begin
        if (start) overrun_d = 1'b1;
        if (cnt_q == '0) begin
          shadow_d = row_result;
          idx_d    = '0;
          state_d  = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRAIN: begin
        if (xfer && is_last) begin
          // A start coinciding with the final transfer chains straight into
          // the next pass without an idle bubble.
          if (start) begin
            state_d = ST_RUN;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (start) overrun_d = 1'b1;
          if (xfer) idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      overrun_q <= overrun_d;
    end
  end

  assign pe_en   = (state_q == ST_RUN);
  assign busy    = (state_q != ST_IDLE);
  assign m_valid = (state_q == ST_DRAIN);
  assign m_data  = m_valid ? slice : '0;
  assign m_index = m_valid ? idx_q : '0;
  assign m_last  = m_valid && is_last;
  assign overrun = overrun_q;

endmodule
